// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide data memory.
// Sub-word stores are a read-modify-write; misaligned or illegal requests are rejected without a memory access.
module load_store_unit (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_misaligned,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic        unsigned_q, unsigned_d;
   logic        mis_q, mis_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] word_q, word_d;

   logic        req_mis;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_value;
   logic [31:0] store_word;

   always_comb begin
      req_mis = (req_size == 2'b11) ||
                (req_size == 2'b01 && req_addr[0]) ||
                (req_size == 2'b10 && req_addr[1:0] != 2'b00);
   end

   always_comb begin
      state_d    = state_q;
      write_d    = write_q;
      unsigned_d = unsigned_q;
      mis_d      = mis_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      word_d     = word_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d    = req_write;
               unsigned_d = req_unsigned;
               mis_d      = req_mis;
               size_d     = req_size;
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               if (req_mis)                      state_d = RESP;
               else if (!req_write)              state_d = RD;
               else if (req_size == 2'b10)       state_d = WR;
               else                              state_d = RD;
            end
         end
         RD: begin
            word_d  = mem_read_data;
            state_d = write_q ? WR : RESP;
         end
         WR:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      byte_lane  = word_q[{addr_q[1:0], 3'b000} +: 8];
      half_lane  = word_q[{addr_q[1], 4'b0000} +: 16];
      load_value = word_q;
      case (size_q)
         2'b00:   load_value = unsigned_q ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
         2'b01:   load_value = unsigned_q ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
         default: load_value = word_q;
      endcase
      store_word = word_q;
      case (size_q)
         2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: store_word = wdata_q;
      endcase
   end

   // req_ready is gated by reset_n so it is low during reset, not only after it
   always_comb begin
      req_ready       = reset_n && (state_q == IDLE);
      resp_valid      = 1'b0;
      resp_rdata      = '0;
      resp_misaligned = 1'b0;
      mem_address     = '0;
      mem_write_data  = '0;
      mem_write       = 1'b0;
      mem_read        = 1'b0;
      case (state_q)
         RD: begin
            mem_read    = 1'b1;
            mem_address = {addr_q[31:2], 2'b00};
         end
         WR: begin
            mem_write      = 1'b1;
            mem_address    = {addr_q[31:2], 2'b00};
            mem_write_data = store_word;
         end
         RESP: begin
            resp_valid      = 1'b1;
            resp_misaligned = mis_q;
            if (!write_q && !mis_q) resp_rdata = load_value;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         write_q    <= 1'b0;
         unsigned_q <= 1'b0;
         mis_q      <= 1'b0;
         size_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         word_q     <= '0;
      end else begin
         state_q    <= state_d;
         write_q    <= write_d;
         unsigned_q <= unsigned_d;
         mis_q      <= mis_d;
         size_q     <= size_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         word_q     <= word_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: per-cycle comparison against a transaction-level model
// plus literal checks of load results, memory contents and latencies.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_misaligned;
   logic [31:0] resp_rdata;
   logic [31:0] mem_address, mem_write_data, mem_read_data;
   logic        mem_write, mem_read;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_misaligned(resp_misaligned), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_write(mem_write), .mem_read(mem_read),
      .mem_read_data(mem_read_data)
   );

   // data memory environment
   logic [31:0] dmem [0:255];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_idx = '0;
   logic [31:0] pre_val = '0;
   assign mem_read_data = dmem[mem_address[9:2]];
   always @(posedge clk) begin
      if (pre_we)         dmem[pre_idx] <= pre_val;
      else if (mem_write) dmem[mem_address[9:2]] <= mem_write_data;
   end

   typedef struct packed {
      logic        ready;
      logic        rv;
      logic        mis;
      logic [31:0] rdata;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   exp_t        expq [$];
   logic [31:0] ref_mem [0:255];
   int          tests = 0, fails = 0;
   int          cycle_n = 0, accept_n = 0, resp_n = 0, accept_cyc = 0, last_lat = 0;
   logic [31:0] last_rdata = '0;
   logic        last_mis = 1'b0;

   // Expected per-cycle outputs for one accepted request, from the access rules.
   function automatic void model_push(input logic w, input logic [1:0] sz, input logic u,
                                      input logic [31:0] ad, input logic [31:0] wd);
      exp_t        acc, fin;
      logic        mis;
      logic [31:0] word, v, aligned;
      int unsigned sh;
      mis     = (sz == 2'd3) || ((ad % (32'd1 << sz)) != 0);
      aligned = ad & ~32'h3;
      word    = ref_mem[ad[9:2]];
      fin     = '0;
      fin.rv  = 1'b1;
      acc     = '0;
      acc.addr = aligned;
      if (mis) begin
         fin.mis = 1'b1;
         expq.push_back(fin);
         return;
      end
      if (!w) begin
         if (sz == 2'd0) begin
            sh = ad[1:0] * 8;
            v  = (word >> sh) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
         end else if (sz == 2'd1) begin
            sh = ad[1] * 16;
            v  = (word >> sh) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
         end else v = word;
         fin.rdata = v;
         acc.rd = 1'b1;
         expq.push_back(acc);
         expq.push_back(fin);
         return;
      end
      if (sz == 2'd2) begin
         acc.wr = 1'b1; acc.wdata = wd;
         expq.push_back(acc);
      end else begin
         acc.rd = 1'b1;
         expq.push_back(acc);
         sh = (sz == 2'd0) ? ad[1:0] * 8 : ad[1] * 16;
         v  = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
         acc.rd = 1'b0; acc.wr = 1'b1;
         acc.wdata = (word & ~(v << sh)) | ((wd & v) << sh);
         expq.push_back(acc);
      end
      expq.push_back(fin);
   endfunction

   // single compare process: one comparison per cycle
   initial begin
      exp_t a, e;
      logic idle;
      forever begin
         @(negedge clk);
         cycle_n++;
         if (pre_we) ref_mem[pre_idx] = pre_val;
         a = {req_ready, resp_valid, resp_misaligned, resp_rdata, mem_read, mem_write,
              mem_address, mem_write_data};
         idle = 1'b0;
         if (!reset_n) begin
            expq.delete();
            e = '0;
         end else if (expq.size() > 0) begin
            e = expq.pop_front();
         end else begin
            e = '0; e.ready = 1'b1; idle = 1'b1;
         end
         tests++;
         if (a !== e) begin
            fails++;
            $display("FAIL cycle%0d: got rdy=%b rv=%b mis=%b rdata=%h rd=%b wr=%b addr=%h wdata=%h required rdy=%b rv=%b mis=%b rdata=%h rd=%b wr=%b addr=%h wdata=%h",
                     cycle_n, a.ready, a.rv, a.mis, a.rdata, a.rd, a.wr, a.addr, a.wdata,
                     e.ready, e.rv, e.mis, e.rdata, e.rd, e.wr, e.addr, e.wdata);
         end
         if (e.wr) ref_mem[e.addr[9:2]] = e.wdata;
         if (resp_valid) begin
            resp_n++;
            last_rdata = resp_rdata;
            last_mis   = resp_misaligned;
            last_lat   = cycle_n - accept_cyc;
         end
         if (idle && req_valid) begin
            model_push(req_write, req_size, req_unsigned, req_addr, req_wdata);
            accept_n++;
            accept_cyc = cycle_n;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] v);
      pre_we = 1'b1; pre_idx = a[9:2]; pre_val = v;
      @(posedge clk); #2;
      pre_we = 1'b0;
   endtask

   task automatic wait_accept(input int old);
      int n;
      n = 0;
      while (accept_n == old && n < 50) begin @(posedge clk); n++; end
      if (accept_n == old) check("accept_timeout", 32'd0, 32'd1);
      #2;
   endtask

   task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] ad, input logic [31:0] wd, input logic keep);
      int old_acc, old_resp, n;
      old_acc = accept_n; old_resp = resp_n;
      req_write = w; req_size = sz; req_unsigned = u; req_addr = ad; req_wdata = wd;
      req_valid = 1'b1;
      wait_accept(old_acc);
      if (!keep) req_valid = 1'b0;
      n = 0;
      while (resp_n == old_resp && n < 50) begin @(posedge clk); n++; end
      if (resp_n == old_resp) check("resp_timeout", 32'd0, 32'd1);
      #2;
   endtask

   initial begin
      int old;
      reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = '0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      #1;
      check("reset_outputs", {31'b0, |{req_ready, resp_valid, resp_misaligned, resp_rdata,
            mem_address, mem_write_data, mem_write, mem_read}}, 32'd0);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      #1 check("ready_after_reset", {31'b0, req_ready}, 32'd1);
      @(posedge clk); #2;
      preload(32'h100, 32'h8877_6655);
      preload(32'h200, 32'h1122_3344);
      preload(32'h300, 32'hCAFE_F00D);

      issue(1'b0, 2'd0, 1'b0, 32'h103, '0, 1'b0);
      check("LB_103", last_rdata, 32'hFFFF_FF88);
      check("LB_latency", last_lat, 32'd2);
      issue(1'b0, 2'd0, 1'b1, 32'h103, '0, 1'b0);
      check("LBU_103", last_rdata, 32'h0000_0088);
      issue(1'b0, 2'd1, 1'b0, 32'h102, '0, 1'b0);
      check("LH_102", last_rdata, 32'hFFFF_8877);
      issue(1'b0, 2'd1, 1'b1, 32'h102, '0, 1'b0);
      check("LHU_102", last_rdata, 32'h0000_8877);
      issue(1'b0, 2'd2, 1'b0, 32'h100, '0, 1'b0);
      check("LW_100", last_rdata, 32'h8877_6655);

      issue(1'b1, 2'd0, 1'b0, 32'h201, 32'h0000_00AB, 1'b0);
      check("SB_latency", last_lat, 32'd3);
      check("SB_mem", dmem[8'h80], 32'h1122_AB44);
      check("SB_rdata", last_rdata, 32'd0);
      issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_BEEF, 1'b0);
      check("SH_mem", dmem[8'h80], 32'hBEEF_AB44);
      check("SH_latency", last_lat, 32'd3);
      issue(1'b1, 2'd2, 1'b0, 32'h100, 32'h1234_5678, 1'b0);
      check("SW_mem", dmem[8'h40], 32'h1234_5678);
      check("SW_latency", last_lat, 32'd2);

      issue(1'b0, 2'd2, 1'b0, 32'h102, '0, 1'b0);
      check("LW_mis_flag", {31'b0, last_mis}, 32'd1);
      check("LW_mis_rdata", last_rdata, 32'd0);
      check("LW_mis_latency", last_lat, 32'd1);
      issue(1'b1, 2'd3, 1'b0, 32'h100, 32'hFFFF_FFFF, 1'b0);
      check("size11_mis_flag", {31'b0, last_mis}, 32'd1);
      check("size11_latency", last_lat, 32'd1);
      check("size11_no_write", dmem[8'h40], 32'h1234_5678);
      issue(1'b0, 2'd1, 1'b1, 32'h101, '0, 1'b0);
      check("LH_odd_mis_flag", {31'b0, last_mis}, 32'd1);

      // reset in the read phase of a byte store
      old = accept_n;
      req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h301; req_wdata = 32'h0000_0077; req_valid = 1'b1;
      wait_accept(old);
      req_valid = 1'b0;
      #1 check("rmw_in_rd", {31'b0, mem_read}, 32'd1);
      reset_n = 1'b0;
      #1 check("reset_mid_outputs", {31'b0, |{req_ready, resp_valid, resp_misaligned, resp_rdata,
               mem_address, mem_write_data, mem_write, mem_read}}, 32'd0);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      #1 check("ready_after_release", {31'b0, req_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #2 check("rmw_discarded", dmem[8'hC0], 32'hCAFE_F00D);

      // req_valid held high across three loads
      issue(1'b0, 2'd2, 1'b0, 32'h100, '0, 1'b1);
      check("b2b_LW", last_rdata, 32'h1234_5678);
      issue(1'b0, 2'd0, 1'b0, 32'h200, '0, 1'b1);
      check("b2b_LB", last_rdata, 32'h0000_0044);
      issue(1'b0, 2'd1, 1'b1, 32'h202, '0, 1'b0);
      check("b2b_LHU", last_rdata, 32'h0000_BEEF);
      check("b2b_accepts", accept_n, 32'd15);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
